// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory port arbiter.
//
// Contents:
//   arb_state_e            arbiter state encoding (IDLE, BUSY)
//   REQ_ICACHE/COMP/DICT   requester indices on the shared port
//   DEFAULT_NUM_REQ        default requester count
//   DEFAULT_TIMEOUT_CYCLES default watchdog limit per memory transaction
package imem_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int REQ_ICACHE = 0;
  localparam int REQ_COMP   = 1;
  localparam int REQ_DICT   = 2;

  localparam int DEFAULT_NUM_REQ        = 3;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage

// File: rtl/imem_arb_pick.sv
// Combinational request picker.
//
// Scans the request vector circularly, starting at start_idx, and reports
// the first set bit. Fixed priority is obtained by tying start_idx to 0.
//
// Ports:
//   req       in  NUM_REQ  request vector
//   start_idx in  IDX_W    first index examined
//   winner    out IDX_W    index of the first set bit found (0 if none)
//   found     out 1        at least one request bit is set
module imem_arb_pick
  import imem_ctrl_pkg::*;
#(
  parameter int NUM_REQ = DEFAULT_NUM_REQ,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start_idx,
  output logic [IDX_W-1:0]   winner,
  output logic               found
);

  int               scan_idx;
  logic [IDX_W-1:0] scan_pos;

  // Walk start_idx, start_idx+1, ... wrapping at NUM_REQ; the first hit is
  // kept because later hits are masked by found.
  always_comb begin
    winner   = '0;
    found    = 1'b0;
    scan_idx = 0;
    scan_pos = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan_idx = int'(start_idx) + i;
      if (scan_idx >= NUM_REQ) begin
        scan_idx = scan_idx - NUM_REQ;
      end
      scan_pos = IDX_W'(scan_idx);
      if (!found && req[scan_pos]) begin
        winner = scan_pos;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// Instruction-memory port arbiter.
//
// Shares one memory request port between the icache refill (0), the
// compressed-cache fill (1) and the dictionary loader (2). The winner's
// index and address are registered, the memory handshake is driven while
// BUSY, and the response is steered back to the winner only. A watchdog
// completes a hung transaction with zero data and sets a sticky error.
//
// Configuration macro IMEM_ARB_ROUND_ROBIN_EN:
//   defined   -> round-robin starting after the last grant
//   undefined -> fixed priority, lowest index wins
//
// Ports:
//   clk, reset     clock; asynchronous active-high reset
//   req_valid      per-requester request, held until its req_ready pulse
//   req_addr       flattened addresses, slice i = [32*i+31:32*i]
//   req_ready      one-cycle completion pulse (one-hot or zero)
//   req_rdata      response data, zero when no req_ready bit is set
//   mem_req_valid  memory request (high in BUSY)
//   mem_req_ready  memory completion pulse, data valid same cycle
//   mem_req_addr   registered memory address
//   mem_req_rdata  memory data
//   grant_id       index of current or last winner
//   busy           high in BUSY
//   timeout_err    sticky watchdog-expiry flag
module imem_port_arbiter
  import imem_ctrl_pkg::*;
#(
  parameter int NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TO_W           = $clog2(TIMEOUT_CYCLES + 1),
  localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [31:0]             req_rdata,
  output logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  output logic [31:0]             mem_req_addr,
  input  logic [31:0]             mem_req_rdata,
  output logic [IDX_W-1:0]        grant_id,
  output logic                    busy,
  output logic                    timeout_err
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [31:0]      addr_q, addr_d;
  logic [TO_W-1:0]  wd_q, wd_d;
  logic             timeout_err_q, timeout_err_d;

  logic [IDX_W-1:0] start_idx;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             wd_expired;
  logic [31:0]      addr_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_addr_unpack
    assign addr_arr[g] = req_addr[32*g +: 32];
  end

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] last_grant_q, last_grant_d;

  // Search begins just after the previous winner so every requester is
  // reached within NUM_REQ grants.
  always_comb begin
    if (last_grant_q == IDX_W'(NUM_REQ - 1)) begin
      start_idx = '0;
    end else begin
      start_idx = last_grant_q + IDX_W'(1);
    end
  end

  // Pointer resets to the top index so requester 0 is first in line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
    end else begin
      last_grant_q <= last_grant_d;
    end
  end
`else
  assign start_idx = IDX_W'(REQ_ICACHE);
`endif

  imem_arb_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req       (req_valid),
    .start_idx (start_idx),
    .winner    (pick_idx),
    .found     (pick_found)
  );

  // Expiry is judged on the current count, so the forced completion lands
  // in the TIMEOUT_CYCLES-th BUSY cycle.
  assign wd_expired = (wd_q == TO_W'(TIMEOUT_CYCLES - 1));

  // Next-state and response steering. A memory completion always takes
  // precedence over watchdog expiry in the same cycle.
  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    addr_d        = addr_q;
    wd_d          = wd_q;
    timeout_err_d = timeout_err_q;
    req_ready     = '0;
    req_rdata     = '0;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    last_grant_d  = last_grant_q;
`endif
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          grant_d = pick_idx;
          addr_d  = addr_arr[pick_idx];
          wd_d    = '0;
          state_d = BUSY;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
          last_grant_d = pick_idx;
`endif
        end
      end
      BUSY: begin
        if (mem_req_ready) begin
          // An aborted requester gets nothing; the data is dropped.
          if (req_valid[grant_q]) begin
            req_ready[grant_q] = 1'b1;
            req_rdata          = mem_req_rdata;
          end
          state_d = IDLE;
        end else if (wd_expired) begin
          req_ready[grant_q] = 1'b1;
          timeout_err_d      = 1'b1;
          state_d            = IDLE;
        end else if (wd_q != {TO_W{1'b1}}) begin
          wd_d = wd_q + TO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      addr_q        <= '0;
      wd_q          <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      addr_q        <= addr_d;
      wd_q          <= wd_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req_valid = (state_q == BUSY);
  assign busy          = (state_q == BUSY);
  assign mem_req_addr  = addr_q;
  assign grant_id      = grant_q;
  assign timeout_err   = timeout_err_q;

endmodule
